// File: rtl/duck_motion_ctl.sv
`default_nettype none
// ============================================================================
// Module   : duck_motion_ctl
// Brief    : Duck flight controller. Spawns the duck at a pseudo-random x
//            position, flies it with wall bounces on a frame-rate tick, and
//            handles the escape, hit-freeze and fall sequences.
// Revision : 1.0 - initial release
// ============================================================================
module duck_motion_ctl #(
    parameter int          TICK_DIV   = 1_083_333,
    parameter int          SCREEN_W   = 1024,
    parameter int          Y_GROUND   = 576,
    parameter int          DUCK_W     = 96,
    parameter int          DUCK_H     = 60,
    parameter int          SPEED_X    = 4,
    parameter int          SPEED_Y    = 3,
    parameter int          FALL_SPEED = 6,
    parameter int          HIT_TICKS  = 30,
    parameter int          FLY_TICKS  = 600,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_enable,
    input  logic        hunt_start,
    input  logic        duck_killed,
    output logic [11:0] duck_xpos,
    output logic [11:0] duck_ypos,
    output logic        duck_dir_left,
    output logic        duck_visible,
    output logic        duck_falling,
    output logic        duck_escaped
);

    // ------------------------------------------------------------------------
    // Derived constants (all position maths is unsigned 12-bit)
    // ------------------------------------------------------------------------
    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FLY_CNT_W = $clog2(FLY_TICKS + 1);
    localparam int HIT_CNT_W = $clog2(HIT_TICKS + 1);

    localparam logic [11:0]          C_X_MAX      = 12'(SCREEN_W - DUCK_W);
    localparam logic [11:0]          C_Y_MAX      = 12'(Y_GROUND - DUCK_H);
    localparam logic [11:0]          C_DUCK_W     = 12'(DUCK_W);
    localparam logic [11:0]          C_SPEED_X    = 12'(SPEED_X);
    localparam logic [11:0]          C_SPEED_Y    = 12'(SPEED_Y);
    localparam logic [11:0]          C_FALL_SPEED = 12'(FALL_SPEED);
    localparam logic [TICK_W-1:0]    C_TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [FLY_CNT_W-1:0] C_FLY_TICKS  = FLY_CNT_W'(FLY_TICKS);
    localparam logic [HIT_CNT_W-1:0] C_HIT_TICKS  = HIT_CNT_W'(HIT_TICKS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_FLY    = 3'd2,
        S_ESCAPE = 3'd3,
        S_HIT    = 3'd4,
        S_FALL   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t                 state_q,    state_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [15:0]            lfsr_q,     lfsr_d;
    logic [FLY_CNT_W-1:0]   fly_cnt_q,  fly_cnt_d;
    logic [HIT_CNT_W-1:0]   hit_cnt_q,  hit_cnt_d;
    logic [11:0]            x_q,        x_d;
    logic [11:0]            y_q,        y_d;
    logic                   left_q,     left_d;
    logic                   up_q,       up_d;
    logic                   visible_q,  visible_d;
    logic                   falling_q,  falling_d;
    logic                   escaped_q,  escaped_d;

    logic                   w_tick;
    logic [11:0]            w_rand_x;
    logic [FLY_CNT_W-1:0]   w_fly_next;
    logic [HIT_CNT_W-1:0]   w_hit_next;

    // Frame tick divider and LFSR both run freely every clock
    always_comb begin
        w_tick     = (tick_cnt_q == C_TICK_LAST);
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Spawn x folds LFSR values past the right limit back on-screen
    always_comb begin
        w_rand_x = {2'b00, lfsr_q[9:0]};
        if (w_rand_x > C_X_MAX) begin
            w_rand_x = w_rand_x - C_DUCK_W;
        end
        w_fly_next = fly_cnt_q + 1'b1;
        w_hit_next = hit_cnt_q + 1'b1;
    end

    // Flight state machine: next state, motion and status outputs
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        left_d    = left_q;
        up_d      = up_q;
        fly_cnt_d = fly_cnt_q;
        hit_cnt_d = hit_cnt_q;
        escaped_d = 1'b0;

        if (!game_enable) begin
            // Disabling the game overrides kills and moves alike
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hunt_start) begin
                        state_d = S_SPAWN;
                    end
                end

                S_SPAWN: begin
                    x_d       = w_rand_x;
                    y_d       = C_Y_MAX;
                    up_d      = 1'b1;
                    left_d    = lfsr_q[10];
                    fly_cnt_d = '0;
                    state_d   = S_FLY;
                end

                S_FLY: begin
                    if (duck_killed) begin
                        hit_cnt_d = '0;
                        state_d   = S_HIT;
                    end else if (w_tick && hunt_start) begin
                        // Horizontal move; compare first so nothing wraps
                        if (!left_q) begin
                            if (x_q + C_SPEED_X >= C_X_MAX) begin
                                x_d    = C_X_MAX;
                                left_d = 1'b1;
                            end else begin
                                x_d = x_q + C_SPEED_X;
                            end
                        end else begin
                            if (x_q <= C_SPEED_X) begin
                                x_d    = '0;
                                left_d = 1'b0;
                            end else begin
                                x_d = x_q - C_SPEED_X;
                            end
                        end
                        // Vertical move
                        if (up_q) begin
                            if (y_q <= C_SPEED_Y) begin
                                y_d  = '0;
                                up_d = 1'b0;
                            end else begin
                                y_d = y_q - C_SPEED_Y;
                            end
                        end else begin
                            if (y_q + C_SPEED_Y >= C_Y_MAX) begin
                                y_d  = C_Y_MAX;
                                up_d = 1'b1;
                            end else begin
                                y_d = y_q + C_SPEED_Y;
                            end
                        end
                        fly_cnt_d = w_fly_next;
                        if (w_fly_next == C_FLY_TICKS) begin
                            state_d = S_ESCAPE;
                        end
                    end
                end

                S_ESCAPE: begin
                    if (duck_killed) begin
                        hit_cnt_d = '0;
                        state_d   = S_HIT;
                    end else if (w_tick) begin
                        if (y_q <= C_SPEED_Y) begin
                            y_d       = '0;
                            escaped_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            y_d = y_q - C_SPEED_Y;
                        end
                    end
                end

                S_HIT: begin
                    // Position frozen; only count ticks
                    if (w_tick) begin
                        hit_cnt_d = w_hit_next;
                        if (w_hit_next == C_HIT_TICKS) begin
                            state_d = S_FALL;
                        end
                    end
                end

                S_FALL: begin
                    if (w_tick) begin
                        if (y_q + C_FALL_SPEED >= C_Y_MAX) begin
                            y_d     = C_Y_MAX;
                            state_d = S_IDLE;
                        end else begin
                            y_d = y_q + C_FALL_SPEED;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Sprite becomes visible together with the loaded spawn position
        visible_d = (state_d == S_FLY) || (state_d == S_ESCAPE) ||
                    (state_d == S_HIT) || (state_d == S_FALL);
        falling_d = (state_d == S_HIT) || (state_d == S_FALL);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            lfsr_q     <= LFSR_SEED;
            fly_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            x_q        <= '0;
            y_q        <= C_Y_MAX;
            left_q     <= 1'b0;
            up_q       <= 1'b1;
            visible_q  <= 1'b0;
            falling_q  <= 1'b0;
            escaped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            lfsr_q     <= lfsr_d;
            fly_cnt_q  <= fly_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            left_q     <= left_d;
            up_q       <= up_d;
            visible_q  <= visible_d;
            falling_q  <= falling_d;
            escaped_q  <= escaped_d;
        end
    end

    assign duck_xpos     = x_q;
    assign duck_ypos     = y_q;
    assign duck_dir_left = left_q;
    assign duck_visible  = visible_q;
    assign duck_falling  = falling_q;
    assign duck_escaped  = escaped_q;

endmodule
`default_nettype wire
